// File: rtl/qdi2bin_1of2_sync.sv
// Clocked receiver for an e1of2 dual-rail QDI channel: synchronizes and debounces the rails,
// runs the 4-phase handshake via Le, and queues recovered bits behind a valid/ready port.
module qdi2bin_1of2_sync #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [1:0]                   L,
    output logic                         Le,
    output logic                         dout,
    output logic                         dvalid,
    input  logic                         dready,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    inout  wire                          VDD,
    inout  wire                          GND
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        NEUTRAL_WAIT = 1'b0,
        IDLE         = 1'b1
    } state_e;

    logic [1:0]             sync_q [SYNC_STAGES];
    logic [1:0]             s_q;
    logic [SYNC_STAGES:0]   primed_q;
    logic [1:0]             s_c;
    logic                   stable_c;
    logic                   data_c;

    state_e                 state_q;
    logic                   le_q;
    logic                   err_q;

    logic [DEPTH-1:0]       mem_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   full_c;
    logic                   push_c;
    logic                   pop_c;

    wire unused_supply = VDD ^ GND;

    // Rail synchronizer; primed_q tracks which stages hold post-reset samples so that
    // the reset value of the chain is never mistaken for a stable neutral.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= 2'b00;
            end
            s_q      <= 2'b00;
            primed_q <= '0;
        end else begin
            sync_q[0] <= L;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_q      <= sync_q[SYNC_STAGES-1];
            primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign s_c      = sync_q[SYNC_STAGES-1];
    assign stable_c = primed_q[SYNC_STAGES] && (s_c == s_q);
    assign data_c   = stable_c && ((s_c == 2'b01) || (s_c == 2'b10));

    assign full_c = (count_q == CNT_W'(DEPTH));
    assign push_c = (state_q == IDLE) && (s_c != 2'b11) && data_c && !full_c;
    assign pop_c  = (count_q != '0) && dready;

    // Handshake FSM; Le mirrors the IDLE state as a registered output.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= NEUTRAL_WAIT;
            le_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                NEUTRAL_WAIT: begin
                    if (stable_c && (s_c == 2'b00)) begin
                        state_q <= IDLE;
                        le_q    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (s_c == 2'b11) begin
                        err_q   <= 1'b1;
                        state_q <= NEUTRAL_WAIT;
                        le_q    <= 1'b0;
                    end else if (push_c) begin
                        state_q <= NEUTRAL_WAIT;
                        le_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= NEUTRAL_WAIT;
                    le_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Token FIFO; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= s_c[1];
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign Le     = le_q;
    assign err    = err_q;
    assign count  = count_q;
    assign dvalid = (count_q != '0);
    assign dout   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_qdi2bin_1of2_sync.sv
// Scoreboard bench for qdi2bin_1of2_sync: a sender model drives the dual-rail handshake,
// expected bits are queued on issue, and a negedge monitor checks every consumed token.
module tb_qdi2bin_1of2_sync;

    logic       clk;
    logic       rst;
    logic [1:0] l;
    logic       le;
    logic       dout;
    logic       dvalid;
    logic       dready;
    logic       err;
    logic [2:0] count;
    wire        vdd = 1'b1;
    wire        gnd = 1'b0;

    int vectors = 0;
    int errors  = 0;
    bit exp_q[$];

    qdi2bin_1of2_sync #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK    (clk),
        .RESET  (rst),
        .L      (l),
        .Le     (le),
        .dout   (dout),
        .dvalid (dvalid),
        .dready (dready),
        .err    (err),
        .count  (count),
        .VDD    (vdd),
        .GND    (gnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_le(input logic v, input string name);
        int n = 0;
        while (le !== v && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(le), 32'(v));
    endtask

    task automatic send_tok(input bit b);
        exp_q.push_back(b);
        wait_le(1'b1, "le_ready");
        l = b ? 2'b10 : 2'b01;
        wait_le(1'b0, "le_ack");
        l = 2'b00;
        wait_le(1'b1, "le_rearm");
    endtask

    // Monitor: every consumed token must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && dvalid && dready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_token: got dout=%0d expected no token at %0t", dout, $time);
            end else begin
                bit e;
                e = exp_q.pop_front();
                chk("dout", 32'(dout), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        l = 2'b00;
        dready = 1'b0;
        repeat (3) tick();
        chk("rst_le", 32'(le), 32'd0);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        // Reset release: Le low through edge 3, high from edge 4.
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("le_low_after_reset", 32'(le), 32'd0);
        end
        tick();
        chk("le_rise_edge4", 32'(le), 32'd1);

        // Tokens 1,0,1 with a free-running consumer; first one timed exactly.
        dready = 1'b1;
        exp_q.push_back(1'b1);
        l = 2'b10;
        repeat (3) tick();
        chk("le_hold_before_push", 32'(le), 32'd1);
        tick();
        chk("le_fall_at_push", 32'(le), 32'd0);
        chk("dvalid_at_push", 32'(dvalid), 32'd1);
        chk("count_at_push", 32'(count), 32'd1);
        l = 2'b00;
        tick();
        chk("dvalid_pulse_end", 32'(dvalid), 32'd0);
        repeat (2) tick();
        chk("le_low_neutral", 32'(le), 32'd0);
        tick();
        chk("le_rise_neutral", 32'(le), 32'd1);
        send_tok(1'b0);
        send_tok(1'b1);
        repeat (2) tick();
        chk("count_drained", 32'(count), 32'd0);

        // Fill the FIFO, then hold the fifth token until one slot frees.
        dready = 1'b0;
        send_tok(1'b0);
        send_tok(1'b1);
        send_tok(1'b1);
        send_tok(1'b0);
        chk("count_full", 32'(count), 32'd4);
        exp_q.push_back(1'b1);
        l = 2'b10;
        repeat (10) tick();
        chk("le_held_full", 32'(le), 32'd1);
        chk("count_held_full", 32'(count), 32'd4);
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("count_after_pop", 32'(count), 32'd3);
        tick();
        chk("count_after_deferred_push", 32'(count), 32'd4);
        chk("le_fall_deferred", 32'(le), 32'd0);
        l = 2'b00;
        wait_le(1'b1, "le_rearm_after_full");
        dready = 1'b1;
        repeat (8) tick();
        chk("count_drained_full", 32'(count), 32'd0);

        // Illegal 11 code: sticky error, no push.
        l = 2'b11;
        wait_le(1'b0, "le_fall_on_11");
        chk("err_set", 32'(err), 32'd1);
        chk("count_no_push_11", 32'(count), 32'd0);
        l = 2'b00;
        wait_le(1'b1, "le_rearm_after_11");
        chk("err_sticky", 32'(err), 32'd1);

        // Reset mid-handshake with two tokens queued.
        dready = 1'b0;
        send_tok(1'b1);
        l = 2'b10;
        wait_le(1'b0, "le_ack_second");
        chk("count_two", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_le", 32'(le), 32'd0);
        chk("midrst_dvalid", 32'(dvalid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("le_low_rails_active", 32'(le), 32'd0);
        chk("count_after_midrst", 32'(count), 32'd0);
        l = 2'b00;
        repeat (3) tick();
        chk("le_low_neutral_settle", 32'(le), 32'd0);
        tick();
        chk("le_rise_after_midrst", 32'(le), 32'd1);

        // Single-cycle glitch must be rejected by the debounce.
        dready = 1'b1;
        l = 2'b01;
        tick();
        l = 2'b00;
        repeat (6) tick();
        chk("glitch_le", 32'(le), 32'd1);
        chk("glitch_count", 32'(count), 32'd0);
        chk("glitch_dvalid", 32'(dvalid), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
